jstk_spi_xfer: RTL
==================

// Module: jstk_spi_xfer
// PURPOSE
//  SPI master for the PmodJSTK joystick; sits directly downstream of the 5 Hz send/receive divider.
//  Each rising edge of sndRec starts one 5-byte SPI frame: LED command out, X/Y/button bytes in.
//  Latches the 40-bit result, pulses data_valid, and is idle again before the next 5 Hz edge.
// PARAMETERS
//  SCLK_HALF      66    CLK cycles per SCLK half-period (100 MHz -> ~758 kHz SCLK)
//  SS_SETUP_CYC   1500  CLK cycles from SS low to first SCLK edge (15 us)
//  BYTE_GAP_CYC   1000  CLK cycles of SCLK-low idle between bytes (10 us)
//  NUM_BYTES      5     bytes per frame
// PORTS
//  CLK         in   1   100 MHz system clock
//  RST         in   1   synchronous reset, active-low (0 = reset)
//  sndRec      in   1   5 Hz request from divider; a rising edge starts a frame
//  leds        in   2   LED1/LED0 state sent in command byte
//  MISO        in   1   SPI data from joystick
//  SS          out  1   SPI slave select, active-low
//  SCLK        out  1   SPI clock, mode 0 (idle low)
//  MOSI        out  1   SPI data to joystick
//  busy        out  1   high from start acceptance until data_valid
//  data_valid  out  1   one-cycle pulse when jstk_data updates
//  jstk_data   out  40  {rx byte0, byte1, byte2, byte3, byte4}, byte0 in [39:32]
// BEHAVIOUR
//  Reset (RST=0 at a CLK edge): SS=1, SCLK=0, MOSI=0, busy=0, data_valid=0, jstk_data=0, FSM=IDLE.
//   Reset mid-frame aborts the frame at once; no data_valid; jstk_data returns to 0.
//  sndRec passes through a 2-flop synchronizer, then a rising-edge detect (sync'd 0->1).
//  FSM states: IDLE -> SETUP -> SHIFT -> (GAP -> SHIFT)* -> DONE -> IDLE.
//   IDLE: SS=1. On edge: busy=1, SS=0, load tx = {6'b100000, leds}, -> SETUP.
//   SETUP: count SS_SETUP_CYC cycles, -> SHIFT.
//   SHIFT: 8 SCLK periods, MSB first. MOSI changes while SCLK low; MISO sampled
//    on the CLK cycle where SCLK goes 0->1. After 8th falling edge: byte_cnt++.
//    If byte_cnt < NUM_BYTES -> GAP, else -> DONE.
//   GAP: SCLK=0, SS stays 0, count BYTE_GAP_CYC cycles, load tx=8'h00, -> SHIFT.
//   DONE: SS=1, jstk_data <= rx shift register, data_valid=1 for exactly 1 cycle,
//    busy=0 on the same cycle; -> IDLE.
//  Start edges while busy=1 are ignored (not queued).
//  Start edge in the same cycle as DONE is ignored; next edge is needed.
//  jstk_data holds its value between frames; only updated in DONE.
//  Counters sized $clog2(max+1); all wrap-free (reload on state entry).
//  Frame length = SS_SETUP_CYC + NUM_BYTES*16*SCLK_HALF + (NUM_BYTES-1)*BYTE_GAP_CYC + ~4 cycles.
// CONFIGURATION
//  JSTK_DECODE_EN defined: extra registered outputs, updated with jstk_data in DONE:
//   x_pos[9:0] = {byte1[1:0], byte0}; y_pos[9:0] = {byte3[1:0], byte2};
//   btn[2:0] = byte4[2:0]; all reset to 0.
//  JSTK_DECODE_EN undefined: these ports and registers do not exist; raw jstk_data only.
// STRUCTURE
//  Package jstk_pkg: FSM state encoding, JSTK_CMD_PREFIX = 6'b100000,
//   default timing constants, byte-index constants for the decode fields.
//  Sub-module spi_byte_shifter: 8-bit mode-0 shift engine (SCLK gen from SCLK_HALF,
//   load/start, MOSI/MISO shift, byte_done pulse); jstk_spi_xfer owns SS, gaps, framing.
// TESTING
//  Bench: SCLK_HALF=2, SS_SETUP_CYC=6, BYTE_GAP_CYC=4; slave model drives MISO on SCLK fall.
//  1 Frame: leds=2'b01, slave returns A5,03,5A,02,05 -> MOSI bytes 81,00,00,00,00;
//    jstk_data=40'hA5035A0205, one data_valid pulse, 40 SCLK rising edges total.
//  2 Timing: SS fall to first SCLK rise = 6+2 cycles; SCLK low between bytes >= 4 cycles; SS=1 in IDLE.
//  3 Retrigger: second sndRec edge while busy -> ignored, exactly one frame; edge after DONE -> new frame.
//  4 Reset mid-frame: RST=0 during byte 2 -> next cycle SS=1, SCLK=0, busy=0, jstk_data=0, no data_valid.
//  5 sndRec held high across frames: only one frame per 0->1 transition.
//  6 JSTK_DECODE_EN build with frame 1 data: x_pos=10'h3A5, y_pos=10'h25A, btn=3'b101.

Source files
------------

// File: rtl/jstk_pkg.sv
// rtl/jstk_pkg.sv - PmodJSTK SPI transfer: state encoding, command prefix, timing defaults, byte indices
package jstk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } jstk_state_t;

  localparam logic [5:0] JSTK_CMD_PREFIX = 6'b100000;

  localparam int DEF_SCLK_HALF    = 66;
  localparam int DEF_SS_SETUP_CYC = 1500;
  localparam int DEF_BYTE_GAP_CYC = 1000;
  localparam int DEF_NUM_BYTES    = 5;

  // Position of each field's byte within the received frame (byte0 first on the wire).
  localparam int BYTE_X_LO = 0;
  localparam int BYTE_X_HI = 1;
  localparam int BYTE_Y_LO = 2;
  localparam int BYTE_Y_HI = 3;
  localparam int BYTE_BTN  = 4;

endpackage

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - 8-bit SPI mode-0 shift engine with SCLK generation and byte_done pulse
module spi_byte_shifter #(
  parameter int SCLK_HALF = 66
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       MISO,
  output logic       SCLK,
  output logic       MOSI,
  output logic [7:0] rx_byte,
  output logic       byte_done
);

  localparam int HW = $clog2(SCLK_HALF + 1);

  logic          running;
  logic [HW-1:0] half_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      running   <= 1'b0;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      rx_byte   <= '0;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (start && !running) begin
        running  <= 1'b1;
        half_cnt <= '0;
        bit_cnt  <= '0;
        tx_sh    <= tx_byte;
        MOSI     <= tx_byte[7];
        SCLK     <= 1'b0;
      end else if (running) begin
        if (half_cnt == HW'(SCLK_HALF - 1)) begin
          half_cnt <= '0;
          if (!SCLK) begin
            SCLK    <= 1'b1;
            rx_byte <= {rx_byte[6:0], MISO};
          end else begin
            // MOSI only moves on the falling edge so it is stable across the next rise.
            SCLK <= 1'b0;
            if (bit_cnt == 3'd7) begin
              running   <= 1'b0;
              byte_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_sh   <= {tx_sh[6:0], 1'b0};
              MOSI    <= tx_sh[6];
            end
          end
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jstk_spi_xfer.sv
// rtl/jstk_spi_xfer.sv - PmodJSTK SPI frame master; JSTK_DECODE_EN adds x_pos/y_pos/btn outputs
module jstk_spi_xfer
  import jstk_pkg::*;
#(
  parameter int SCLK_HALF    = DEF_SCLK_HALF,
  parameter int SS_SETUP_CYC = DEF_SS_SETUP_CYC,
  parameter int BYTE_GAP_CYC = DEF_BYTE_GAP_CYC,
  parameter int NUM_BYTES    = DEF_NUM_BYTES
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   sndRec,
  input  logic [1:0]             leds,
  input  logic                   MISO,
  output logic                   SS,
  output logic                   SCLK,
  output logic                   MOSI,
  output logic                   busy,
  output logic                   data_valid,
`ifdef JSTK_DECODE_EN
  output logic [9:0]             x_pos,
  output logic [9:0]             y_pos,
  output logic [2:0]             btn,
`endif
  output logic [8*NUM_BYTES-1:0] jstk_data
);

  localparam int CNT_MAX = (SS_SETUP_CYC > BYTE_GAP_CYC) ? SS_SETUP_CYC : BYTE_GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(NUM_BYTES + 1);
  localparam int DW      = 8 * NUM_BYTES;

  jstk_state_t   state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] byte_cnt;
  logic [2:0]    snd_sync;
  logic [7:0]    tx;
  logic [DW-1:0] rx;
  logic [7:0]    rx_byte;
  logic          byte_done;
  logic          start_edge;
  logic          sh_start;

  assign start_edge = snd_sync[1] & ~snd_sync[2];

  // Shifter is launched on the last counted cycle so SETUP/GAP last exactly their cycle count.
  assign sh_start = ((state == ST_SETUP) && (cnt == CW'(SS_SETUP_CYC - 1))) ||
                    ((state == ST_GAP)   && (cnt == CW'(BYTE_GAP_CYC - 1)));

  spi_byte_shifter #(.SCLK_HALF(SCLK_HALF)) u_shifter (
    .CLK      (CLK),
    .RST      (RST),
    .start    (sh_start),
    .tx_byte  (tx),
    .MISO     (MISO),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .rx_byte  (rx_byte),
    .byte_done(byte_done)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      byte_cnt   <= '0;
      snd_sync   <= '0;
      tx         <= '0;
      rx         <= '0;
      SS         <= 1'b1;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      jstk_data  <= '0;
`ifdef JSTK_DECODE_EN
      x_pos      <= '0;
      y_pos      <= '0;
      btn        <= '0;
`endif
    end else begin
      snd_sync   <= {snd_sync[1:0], sndRec};
      data_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          SS <= 1'b1;
          if (start_edge) begin
            busy     <= 1'b1;
            SS       <= 1'b0;
            tx       <= {JSTK_CMD_PREFIX, leds};
            cnt      <= '0;
            byte_cnt <= '0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt <= cnt + 1'b1;
          if (sh_start) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (byte_done) begin
            rx       <= {rx[DW-9:0], rx_byte};
            byte_cnt <= byte_cnt + 1'b1;
            cnt      <= '0;
            tx       <= 8'h00;
            state    <= (byte_cnt == BW'(NUM_BYTES - 1)) ? ST_DONE : ST_GAP;
          end
        end
        ST_GAP: begin
          cnt <= cnt + 1'b1;
          if (sh_start) state <= ST_SHIFT;
        end
        ST_DONE: begin
          SS         <= 1'b1;
          jstk_data  <= rx;
          data_valid <= 1'b1;
          busy       <= 1'b0;
`ifdef JSTK_DECODE_EN
          x_pos      <= {rx[8*(NUM_BYTES-1-BYTE_X_HI) +: 2], rx[8*(NUM_BYTES-1-BYTE_X_LO) +: 8]};
          y_pos      <= {rx[8*(NUM_BYTES-1-BYTE_Y_HI) +: 2], rx[8*(NUM_BYTES-1-BYTE_Y_LO) +: 8]};
          btn        <= rx[8*(NUM_BYTES-1-BYTE_BTN) +: 3];
`endif
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
